// File: rtl/ram_pipe.sv
// ram_pipe: single-port, byte-maskable RAM with a fixed-latency read pipeline
// and a self-sequenced zero-fill (clear) engine.
//
// Ports:
//   clk         - rising-edge clock for all state
//   rst_n       - synchronous active-low reset
//   req_valid   - request present
//   req_ready   - request accepted this cycle when high together with req_valid
//   addr        - word address
//   wen         - 1 = write, 0 = read
//   be          - per-byte write enable (ignored on reads)
//   data_in     - write data
//   clr         - single-cycle pulse requesting a runtime zero-fill
//   rsp_valid   - one-cycle pulse per read, READ_LATENCY cycles after accept
//   data_out    - read data, held between responses
//   busy        - high while a clear is in progress
//   dbg_state_o - current FSM state (0 = CLEAR, 1 = IDLE)
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is combinational, high only in IDLE with no clr pulse present, and
// does not depend on req_valid. Responses have no backpressure.

module ram_pipe #(
    parameter int BIT_SIZE       = 1024,
    parameter int BIT_DEPTH      = 8,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1,
    localparam int WORDS = BIT_SIZE / BIT_DEPTH,
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int LANES = BIT_DEPTH / 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [AW-1:0]        addr,
    input  logic                 wen,
    input  logic [LANES-1:0]     be,
    input  logic [BIT_DEPTH-1:0] data_in,
    input  logic                 clr,
    output logic                 rsp_valid,
    output logic [BIT_DEPTH-1:0] data_out,
    output logic                 busy,
    output logic                 dbg_state_o
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    localparam state_e          RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
    localparam logic [AW-1:0]   LAST_ADDR = AW'(WORDS - 1);

    state_e               state_q, state_d;
    logic [AW-1:0]        clr_cnt_q, clr_cnt_d;

    logic                 accept;
    logic                 wr_accept;
    logic                 rd_accept;
    logic [BIT_DEPTH-1:0] rd_word;
    logic                 rsp_valid_q;
    logic [BIT_DEPTH-1:0] data_out_q;

    logic [BIT_DEPTH-1:0] mem_q [WORDS];

    // clr has priority over a request presented in the same IDLE cycle.
    assign req_ready   = (state_q == ST_IDLE) && !clr;
    assign accept      = req_valid && req_ready;
    assign wr_accept   = accept && wen;
    assign rd_accept   = accept && !wen;
    assign busy        = (state_q == ST_CLEAR);
    assign dbg_state_o = state_q;
    assign rsp_valid   = rsp_valid_q;
    assign data_out    = data_out_q;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RST_STATE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                // One word zeroed per cycle; leave on the edge that writes the top word.
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = RST_STATE;
                clr_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage. Clear and request writes are exclusive because req_ready is
    // low throughout CLEAR. The array itself is not reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == ST_CLEAR) begin
                mem_q[clr_cnt_q] <= '0;
            end else if (wr_accept) begin
                for (int k = 0; k < LANES; k++) begin
                    if (be[k]) begin
                        mem_q[addr][8*k +: 8] <= data_in[8*k +: 8];
                    end
                end
            end
        end
    end

    // Read data is captured at the accept edge, so a clear that starts
    // afterwards cannot disturb a read already in the pipeline.
    assign rd_word = mem_q[addr];

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                 s1_valid_q;
            logic [BIT_DEPTH-1:0] s1_data_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s1_valid_q  <= 1'b0;
                    s1_data_q   <= '0;
                    rsp_valid_q <= 1'b0;
                    data_out_q  <= '0;
                end else begin
                    s1_valid_q  <= rd_accept;
                    if (rd_accept) begin
                        s1_data_q <= rd_word;
                    end
                    rsp_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        data_out_q <= s1_data_q;
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rsp_valid_q <= 1'b0;
                    data_out_q  <= '0;
                end else begin
                    rsp_valid_q <= rd_accept;
                    if (rd_accept) begin
                        data_out_q <= rd_word;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ram_pipe.sv
// tb_ram_pipe: directed bench for ram_pipe. Two instances share all inputs:
// u_lat1 with READ_LATENCY=1 and u_lat2 with READ_LATENCY=2. Inputs change
// right after the falling edge; outputs are sampled at the falling edge.

module tb_ram_pipe;

    localparam int BIT_SIZE  = 4096;
    localparam int BIT_DEPTH = 32;
    localparam int WORDS     = 128;
    localparam int AW        = 7;
    localparam int LANES     = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic [AW-1:0]    addr;
    logic             wen;
    logic [LANES-1:0] be;
    logic [31:0]      data_in;
    logic             clr;

    logic             rdy1, rv1, busy1, st1;
    logic [31:0]      do1;
    logic             rdy2, rv2, busy2, st2;
    logic [31:0]      do2;

    int               n_checks = 0;
    int               n_pass   = 0;
    int               c1, c2, guard;
    logic             saw_ready, saw_rsp;
    logic [31:0]      model [WORDS];

    always #5 clk = ~clk;

    ram_pipe #(
        .BIT_SIZE(BIT_SIZE), .BIT_DEPTH(BIT_DEPTH), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
    ) u_lat1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1),
        .addr(addr), .wen(wen), .be(be), .data_in(data_in), .clr(clr),
        .rsp_valid(rv1), .data_out(do1), .busy(busy1), .dbg_state_o(st1)
    );

    ram_pipe #(
        .BIT_SIZE(BIT_SIZE), .BIT_DEPTH(BIT_DEPTH), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
    ) u_lat2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy2),
        .addr(addr), .wen(wen), .be(be), .data_in(data_in), .clr(clr),
        .rsp_valid(rv2), .data_out(do2), .busy(busy2), .dbg_state_o(st2)
    );

    // ---------------- driver tasks ----------------
    task automatic idle();
        req_valid = 1'b0;
        wen       = 1'b0;
        clr       = 1'b0;
        @(negedge clk);
    endtask

    task automatic drive_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
        req_valid = 1'b1;
        wen       = 1'b1;
        addr      = a;
        data_in   = d;
        be        = b;
        clr       = 1'b0;
        @(negedge clk);
    endtask

    // be is driven all-ones on reads: it must have no effect.
    task automatic drive_read(input logic [AW-1:0] a);
        req_valid = 1'b1;
        wen       = 1'b0;
        addr      = a;
        data_in   = 32'hFFFF_FFFF;
        be        = 4'hF;
        clr       = 1'b0;
        @(negedge clk);
    endtask

    // Runs from a falling edge where a clear is in progress until busy drops,
    // counting busy cycles per instance and noting any req_ready or rsp_valid.
    task automatic wait_clear(input int clr_pulse_at);
        c1 = 0; c2 = 0; guard = 0; saw_ready = 1'b0; saw_rsp = 1'b0;
        while ((busy1 || busy2) && guard < 300) begin
            if (busy1) c1++;
            if (busy2) c2++;
            clr = (guard == clr_pulse_at);
            #1;
            if (rdy1 || rdy2) saw_ready = 1'b1;
            guard++;
            @(negedge clk);
            if (rv1 || rv2) saw_rsp = 1'b1;
        end
        clr = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int addrs [3];
        addrs = '{0, 64, 127};
        rst_n = 1'b0; req_valid = 1'b0; wen = 1'b0; clr = 1'b0;
        addr = '0; be = '0; data_in = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rv1, do1, busy1, rdy1} !== {1'b0, 32'h0, 1'b1, 1'b0})
            $display("FAIL reset_state_lat1: got rv=%b do=%h busy=%b rdy=%b, expected 0 0 1 0", rv1, do1, busy1, rdy1);
        else n_pass++;
        n_checks++;
        if ({rv2, do2, busy2, rdy2} !== {1'b0, 32'h0, 1'b1, 1'b0})
            $display("FAIL reset_state_lat2: got rv=%b do=%h busy=%b rdy=%b, expected 0 0 1 0", rv2, do2, busy2, rdy2);
        else n_pass++;

        rst_n = 1'b1;
        wait_clear(-1);
        n_checks++;
        if (c1 !== 128 || c2 !== 128)
            $display("FAIL reset_clear_len: got %0d/%0d busy cycles, expected 128", c1, c2);
        else n_pass++;
        n_checks++;
        if (saw_ready !== 1'b0)
            $display("FAIL reset_clear_ready: got req_ready=1 during clear, expected 0");
        else n_pass++;

        foreach (addrs[j]) begin
            drive_read(AW'(addrs[j]));
            n_checks++;
            if ({rv1, do1, rv2} !== {1'b1, 32'h0, 1'b0})
                $display("FAIL zero_read_lat1 a=%0d: got rv1=%b do1=%h rv2=%b, expected 1 0 0", addrs[j], rv1, do1, rv2);
            else n_pass++;
            idle();
            n_checks++;
            if ({rv2, do2, rv1} !== {1'b1, 32'h0, 1'b0})
                $display("FAIL zero_read_lat2 a=%0d: got rv2=%b do2=%h rv1=%b, expected 1 0 0", addrs[j], rv2, do2, rv1);
            else n_pass++;
        end
    endtask

    task automatic test_byte_enable();
        drive_write(7'd5, 32'hDEAD_BEEF, 4'hF);
        drive_write(7'd5, 32'h1122_3344, 4'b0101);
        n_checks++;
        if ({rv1, rv2} !== 2'b00)
            $display("FAIL write_no_rsp: got rv1=%b rv2=%b, expected 0 0", rv1, rv2);
        else n_pass++;
        drive_write(7'd5, 32'hFFFF_FFFF, 4'h0);
        idle();
        n_checks++;
        if ({rv1, rv2} !== 2'b00)
            $display("FAIL be0_no_rsp: got rv1=%b rv2=%b, expected 0 0", rv1, rv2);
        else n_pass++;
        drive_read(7'd5);
        n_checks++;
        if ({rv1, do1} !== {1'b1, 32'hDE22_BE44})
            $display("FAIL byte_lanes_lat1: got rv=%b do=%h, expected 1 de22be44", rv1, do1);
        else n_pass++;
        idle();
        n_checks++;
        if ({rv2, do2} !== {1'b1, 32'hDE22_BE44})
            $display("FAIL byte_lanes_lat2: got rv=%b do=%h, expected 1 de22be44", rv2, do2);
        else n_pass++;
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < WORDS; i++) begin
            model[i] = $urandom;
            drive_write(AW'(i), model[i], 4'hF);
        end
        for (int i = 0; i < WORDS; i++) begin
            drive_read(AW'(i));
            n_checks++;
            if ({rv1, do1} !== {1'b1, model[i]})
                $display("FAIL b2b_lat1 i=%0d: got rv=%b do=%h, expected 1 %h", i, rv1, do1, model[i]);
            else n_pass++;
            n_checks++;
            if (i == 0) begin
                if (rv2 !== 1'b0)
                    $display("FAIL b2b_lat2_early: got rv=%b, expected 0", rv2);
                else n_pass++;
            end else begin
                if ({rv2, do2} !== {1'b1, model[i-1]})
                    $display("FAIL b2b_lat2 i=%0d: got rv=%b do=%h, expected 1 %h", i-1, rv2, do2, model[i-1]);
                else n_pass++;
            end
        end
        idle();
        n_checks++;
        if ({rv1, do1, rv2, do2} !== {1'b0, model[WORDS-1], 1'b1, model[WORDS-1]})
            $display("FAIL b2b_tail: got rv1=%b do1=%h rv2=%b do2=%h, expected 0 %h 1 %h",
                     rv1, do1, rv2, do2, model[WORDS-1], model[WORDS-1]);
        else n_pass++;
        idle();
        n_checks++;
        if ({rv1, do1, rv2, do2} !== {1'b0, model[WORDS-1], 1'b0, model[WORDS-1]})
            $display("FAIL hold_data: got rv1=%b do1=%h rv2=%b do2=%h, expected 0 %h 0 %h",
                     rv1, do1, rv2, do2, model[WORDS-1], model[WORDS-1]);
        else n_pass++;
    endtask

    task automatic test_raw();
        drive_write(7'd9, 32'hA5A5_A5A5, 4'hF);
        drive_read(7'd9);
        n_checks++;
        if ({rv1, do1} !== {1'b1, 32'hA5A5_A5A5})
            $display("FAIL raw_lat1: got rv=%b do=%h, expected 1 a5a5a5a5", rv1, do1);
        else n_pass++;
        idle();
        n_checks++;
        if ({rv2, do2} !== {1'b1, 32'hA5A5_A5A5})
            $display("FAIL raw_lat2: got rv=%b do=%h, expected 1 a5a5a5a5", rv2, do2);
        else n_pass++;
        idle();
    endtask

    task automatic test_clear();
        drive_read(7'd9);
        n_checks++;
        if ({rv1, do1} !== {1'b1, 32'hA5A5_A5A5})
            $display("FAIL preclr_read_lat1: got rv=%b do=%h, expected 1 a5a5a5a5", rv1, do1);
        else n_pass++;
        // clr and a read request in the same cycle: clr wins.
        clr = 1'b1;
        #1;
        n_checks++;
        if ({rdy1, rdy2} !== 2'b00)
            $display("FAIL clr_blocks_ready: got rdy1=%b rdy2=%b, expected 0 0", rdy1, rdy2);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (rv1 !== 1'b0)
            $display("FAIL clr_req_rejected: got rv1=%b, expected 0", rv1);
        else n_pass++;
        n_checks++;
        if ({rv2, do2} !== {1'b1, 32'hA5A5_A5A5})
            $display("FAIL preclr_read_lat2: got rv=%b do=%h, expected 1 a5a5a5a5", rv2, do2);
        else n_pass++;
        // Keep requesting during the clear, and pulse clr once mid-way (ignored).
        clr = 1'b0;
        wait_clear(60);
        req_valid = 1'b0;
        n_checks++;
        if (c1 !== 128 || c2 !== 128)
            $display("FAIL clr_len: got %0d/%0d busy cycles, expected 128", c1, c2);
        else n_pass++;
        n_checks++;
        if ({saw_ready, saw_rsp} !== 2'b00)
            $display("FAIL clr_quiet: got ready_seen=%b rsp_seen=%b, expected 0 0", saw_ready, saw_rsp);
        else n_pass++;
        drive_read(7'd9);
        n_checks++;
        if ({rv1, do1} !== {1'b1, 32'h0})
            $display("FAIL postclr_read_lat1: got rv=%b do=%h, expected 1 0", rv1, do1);
        else n_pass++;
        drive_read(7'd100);
        n_checks++;
        if ({rv1, do1, rv2, do2} !== {1'b1, 32'h0, 1'b1, 32'h0})
            $display("FAIL postclr_read_b2b: got rv1=%b do1=%h rv2=%b do2=%h, expected 1 0 1 0", rv1, do1, rv2, do2);
        else n_pass++;
        idle();
        idle();
    endtask

    task automatic test_reset_mid_clear();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy1, busy2, rv1, rv2} !== 4'b1100)
            $display("FAIL midclr_reset_state: got busy=%b%b rv=%b%b, expected 11 00", busy1, busy2, rv1, rv2);
        else n_pass++;
        rst_n = 1'b1;
        wait_clear(-1);
        n_checks++;
        if (c1 !== 128 || c2 !== 128)
            $display("FAIL midclr_restart_len: got %0d/%0d busy cycles, expected 128", c1, c2);
        else n_pass++;
        n_checks++;
        if (saw_rsp !== 1'b0)
            $display("FAIL midclr_no_rsp: got rsp_valid during restarted clear, expected none");
        else n_pass++;

        // Read in flight when reset hits: the latency-2 response is discarded.
        drive_write(7'd3, 32'h1357_2468, 4'hF);
        drive_read(7'd3);
        n_checks++;
        if ({rv1, do1} !== {1'b1, 32'h1357_2468})
            $display("FAIL inflight_lat1: got rv=%b do=%h, expected 1 13572468", rv1, do1);
        else n_pass++;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rv1, do1, rv2, do2} !== {1'b0, 32'h0, 1'b0, 32'h0})
            $display("FAIL reset_flush: got rv1=%b do1=%h rv2=%b do2=%h, expected 0 0 0 0", rv1, do1, rv2, do2);
        else n_pass++;
        rst_n = 1'b1;
        wait_clear(-1);
        n_checks++;
        if (c1 !== 128 || c2 !== 128 || saw_rsp !== 1'b0)
            $display("FAIL post_flush_clear: got %0d/%0d busy cycles rsp_seen=%b, expected 128 0", c1, c2, saw_rsp);
        else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_byte_enable();
        test_back_to_back();
        test_raw();
        test_clear();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, expected finish earlier");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ram_pipe.md
RAM_PIPE -- requirements
Module: ram_pipe

Interface
REQ-001 Parameter BIT_SIZE, default 1024: total storage in bits; WORDS = BIT_SIZE/BIT_DEPTH; AW = $clog2(WORDS).
REQ-002 Parameter BIT_DEPTH, default 8: word width in bits; multiple of 8; LANES = BIT_DEPTH/8.
REQ-003 Parameter READ_LATENCY, default 1: accept-to-rsp_valid delay in cycles; legal values 1 or 2.
REQ-004 Parameter CLEAR_ON_RESET, default 1: 1 = zero-fill the whole array after reset; 0 = contents undefined after reset.
REQ-005 The block SHALL use one clock; reset is synchronous and active-low.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 req_valid  in  1  request present.
REQ-009 req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-010 addr  in  AW  word address.
REQ-011 wen  in  1  1 = write, 0 = read.
REQ-012 be  in  LANES  per-byte write enable; ignored on reads.
REQ-013 data_in  in  BIT_DEPTH  write data.
REQ-014 clr  in  1  single-cycle pulse requesting a runtime zero-fill.
REQ-015 rsp_valid  out  1  read data valid, one-cycle pulse per read.
REQ-016 data_out  out  BIT_DEPTH  read data.
REQ-017 busy  out  1  high while a clear is in progress.

Function
REQ-018 The FSM SHALL have two states, CLEAR and IDLE; req_ready = (state==IDLE) && !clr, combinational.
REQ-019 A request SHALL be accepted on every rising edge where req_valid && req_ready are both high; throughput is one request per cycle with no bubbles.
REQ-020 An accepted write SHALL update, at that edge, exactly the byte lanes with be[k]=1 (bits 8k+7:8k); other lanes unchanged; no response generated.
REQ-021 An accepted write with be all-zero SHALL be a no-op with no response.
REQ-022 An accepted read SHALL raise rsp_valid exactly READ_LATENCY cycles after the accept edge, with data_out holding the word at that address.
REQ-023 rsp_valid SHALL have no backpressure; back-to-back reads SHALL yield back-to-back rsp_valid pulses in request order.
REQ-024 data_out SHALL hold its last read value while rsp_valid is low.
REQ-025 A read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-026 In CLEAR, the block SHALL write all-zero to one address per cycle, ascending 0..WORDS-1, then enter IDLE on the edge after writing WORDS-1; duration is exactly WORDS cycles with busy=1 throughout.
REQ-027 clr=1 in IDLE SHALL enter CLEAR from address 0 on the next edge; clr is ignored in CLEAR.
REQ-028 clr and req_valid high in the same IDLE cycle: clr wins; the request is not accepted (req_ready=0).
REQ-029 Reads accepted before a clr SHALL still complete with pre-clear data at their normal latency.
REQ-030 Address wrap: no address outside 0..WORDS-1 exists; addr values are used as-is (WORDS is a power of two).

Reset
REQ-031 While rst_n=0 at a rising edge: rsp_valid=0, data_out=0, read pipeline flushed, clear counter=0.
REQ-032 After reset the state SHALL be CLEAR if CLEAR_ON_RESET=1 (busy=1, req_ready=0), otherwise IDLE (busy=0).
REQ-033 Reset during CLEAR SHALL restart the clear from address 0 with a full WORDS-cycle duration.
REQ-034 Reset SHALL discard in-flight reads; no rsp_valid after reset for pre-reset requests.

Verification (BIT_SIZE=4096, BIT_DEPTH=32, WORDS=128, LANES=4 unless stated)
REQ-035 Release rst_n -> busy=1 and req_ready=0 for exactly 128 cycles; then reads of addresses 0, 64, and 127 return 32'h0.
REQ-036 Write 32'hDEADBEEF, be=4'hF, addr 5, then write 32'h11223344, be=4'b0101, addr 5 -> a read of addr 5 returns 32'hDE22BE44.
REQ-037 READ_LATENCY=1 and then 2: 128 back-to-back writes of $random followed by 128 back-to-back reads -> 128 consecutive rsp_valid pulses, each at accept+READ_LATENCY, all matching the model.
REQ-038 Write addr 9 = 32'hA5A5A5A5, then read addr 9 on the next cycle -> returns 32'hA5A5A5A5.
REQ-039 clr pulsed with req_valid high the same cycle -> that request is not accepted; busy=1 for 128 cycles; a read of the previously written addr 9 then returns 0.
REQ-040 Assert rst_n=0 at clear cycle 50, release it -> a full 128-cycle clear follows, and no stale rsp_valid appears.
